// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-outstanding instruction fetcher feeding a 2-entry buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY    = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic [31:0] fetch_pc;
   logic [31:0] req_addr;
   logic [1:0]  count;
   logic [1:0]  count_after;
   logic        rd_ptr;
   logic        wr_ptr;
   logic        push;
   logic        pop;
   logic [31:0] buf_instr [2];
   logic [31:0] buf_pc    [2];
   logic        unused_ok;

   assign unused_ok   = &{1'b0, redirect_pc[1:0], 1'b0};
   assign instr_valid = (count != 2'd0);
   assign pop         = instr_valid && instr_ready;
   assign push        = (state == BUSY) && imem_ack && !redirect;
   assign count_after = count + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A buffer slot is reserved when a request issues, so BUSY never sees a full buffer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!redirect && (count < 2'd2)) state_next = BUSY;
         end
         BUSY: begin
            if (redirect) begin
               state_next = imem_ack ? IDLE : DISCARD;
            end else if (imem_ack) begin
               state_next = (count_after < 2'd2) ? BUSY : IDLE;
            end
         end
         DISCARD: begin
            if (imem_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      imem_req = (state == BUSY) || (state == DISCARD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_addr <= 32'h0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else begin
         if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + 32'd4;
               wr_ptr   <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_after;
         end
         // The request address only moves when a new request is issued.
         if ((state == IDLE) && (state_next == BUSY)) begin
            req_addr <= fetch_pc;
         end else if (push && (state_next == BUSY)) begin
            req_addr <= fetch_pc + 32'd4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]    <= fetch_pc;
      end
   end

   assign imem_addr = req_addr;
   assign instr     = instr_valid ? buf_instr[rd_ptr] : 32'h0;
   assign instr_pc  = instr_valid ? buf_pc[rd_ptr]    : 32'h0;
   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7    = instr[31:25];

endmodule
`default_nettype wire
